// File: rtl/mux_2to1_if.sv
// Signal bundle for mux_2to1: data/select inputs plus the combinational and
// registered outputs. The bench drives the master side and the mux implements the slave side.
interface mux_2to1_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             sel_q;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output a, b, sel,
        input  y, y_q, sel_q, toggle_cnt
    );

    modport slave (
        input  a, b, sel,
        output y, y_q, sel_q, toggle_cnt
    );
endinterface

// File: rtl/mux_2to1.sv
// 2:1 multiplexer with a combinational output and a registered copy. It also
// keeps a saturating count of sampled select changes for observability.
module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_2to1_if.slave     bus
);
    logic [WIDTH-1:0] y_c;
    logic [WIDTH-1:0] y_r;
    logic             sel_r;
    logic [CNT_W-1:0] cnt_r;

    // Pure function of the inputs; no clock or reset in this path.
    always_comb begin
        y_c = bus.sel ? bus.b : bus.a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_r   <= '0;
            sel_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            y_r   <= y_c;
            sel_r <= bus.sel;
            // Compare against the previously sampled select, so glitches between edges never count.
            if ((bus.sel != sel_r) && (cnt_r != '1)) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign bus.y          = y_c;
    assign bus.y_q        = y_r;
    assign bus.sel_q      = sel_r;
    assign bus.toggle_cnt = cnt_r;
endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: a WIDTH=8/CNT_W=8 instance and a
// WIDTH=1/CNT_W=2 instance, checked against a behavioural reference model.
module tb_mux_2to1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    mux_2to1_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
    mux_2to1_if #(.WIDTH(1), .CNT_W(2)) bus1 ();

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    mux_2to1 #(.WIDTH(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Clock only runs once clk_en is set, so the combinational checks run with no clock.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference model state: index 0 = 8-bit instance, index 1 = 1-bit instance.
    int         m_cnt  [2];
    int         m_max  [2] = '{255, 3};
    logic       m_sel  [2];
    logic [7:0] m_yq   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic r, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (r) begin
            m_cnt[k] = 0;
            m_sel[k] = 1'b0;
            m_yq[k]  = 8'h00;
        end else begin
            m_yq[k] = s ? b : a;
            if (s != m_sel[k]) m_cnt[k] = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_cnt[k];
            m_sel[k] = s;
        end
    endtask

    // One rising edge: sample the inputs just before it, update the model, compare after it.
    task automatic tick();
        logic       r;
        logic       s8, s1;
        logic [7:0] a8, b8, a1, b1;
        r  = rst;
        s8 = bus8.sel; a8 = bus8.a;        b8 = bus8.b;
        s1 = bus1.sel; a1 = {7'd0, bus1.a}; b1 = {7'd0, bus1.b};
        @(posedge clk);
        model_edge(0, r, s8, a8, b8);
        model_edge(1, r, s1, a1, b1);
        #1;
        check("y_q8",   {24'd0, bus8.y_q},       {24'd0, m_yq[0]});
        check("sel_q8", {31'd0, bus8.sel_q},     {31'd0, m_sel[0]});
        check("cnt8",   {24'd0, bus8.toggle_cnt}, m_cnt[0]);
        check("y_q1",   {31'd0, bus1.y_q},       {24'd0, m_yq[1]});
        check("sel_q1", {31'd0, bus1.sel_q},     {31'd0, m_sel[1]});
        check("cnt1",   {30'd0, bus1.toggle_cnt}, m_cnt[1]);
    endtask

    typedef struct {
        bit         w8;
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b0, 8'h0, 8'h0, 1'b0, 8'h0};
        vecs[1] = '{1'b0, 8'h0, 8'h0, 1'b1, 8'h0};
        vecs[2] = '{1'b0, 8'h0, 8'h1, 1'b0, 8'h0};
        vecs[3] = '{1'b0, 8'h0, 8'h1, 1'b1, 8'h1};
        vecs[4] = '{1'b0, 8'h1, 8'h0, 1'b0, 8'h1};
        vecs[5] = '{1'b0, 8'h1, 8'h0, 1'b1, 8'h0};
        vecs[6] = '{1'b0, 8'h1, 8'h1, 1'b0, 8'h1};
        vecs[7] = '{1'b0, 8'h1, 8'h1, 1'b1, 8'h1};
        vecs[8] = '{1'b1, 8'h5A, 8'hA5, 1'b0, 8'h5A};
        vecs[9] = '{1'b1, 8'h5A, 8'hA5, 1'b1, 8'hA5};

        bus8.a = 8'h00; bus8.b = 8'h01; bus8.sel = 1'b0;
        bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.sel = 1'b0;

        // Combinational path with the clock stopped.
        #1 check("comb_sel0", {24'd0, bus8.y}, 32'h0);
        bus8.sel = 1'b1;
        #10 check("comb_sel1", {24'd0, bus8.y}, 32'h1);
        bus8.a = 8'h01; bus8.sel = 1'b0;
        #1 check("comb_a1", {24'd0, bus8.y}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].w8) begin
                bus8.a = vecs[i].a; bus8.b = vecs[i].b; bus8.sel = vecs[i].sel;
                #1 check($sformatf("vec%0d_y8", i), {24'd0, bus8.y}, {24'd0, vecs[i].exp_y});
            end else begin
                bus1.a = vecs[i].a[0]; bus1.b = vecs[i].b[0]; bus1.sel = vecs[i].sel;
                #1 check($sformatf("vec%0d_y1", i), {31'd0, bus1.y}, {24'd0, vecs[i].exp_y});
            end
        end

        // Registered path: reset, then a first transaction.
        clk_en = 1'b1;
        rst = 1'b1; bus8.sel = 1'b0; bus1.sel = 1'b0;
        tick();
        check("rst_cnt8", {24'd0, bus8.toggle_cnt}, 32'd0);
        rst = 1'b0;
        bus8.a = 8'h3C; bus8.b = 8'hC3; bus8.sel = 1'b1;
        #1;
        check("pre_y_q", {24'd0, bus8.y_q}, 32'h0);
        check("pre_sel_q", {31'd0, bus8.sel_q}, 32'h0);
        tick();
        check("first_y_q", {24'd0, bus8.y_q}, 32'hC3);
        check("first_sel_q", {31'd0, bus8.sel_q}, 32'h1);

        // Toggle counter sequence 1,0,0,1,1 -> 1,2,2,3,3; CNT_W=2 instance alternates and saturates.
        begin
            logic       seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            int         exp8[5] = '{1, 2, 2, 3, 3};
            int         exp1[6] = '{1, 2, 3, 3, 3, 3};
            rst = 1'b1; bus8.sel = 1'b0; bus1.sel = 1'b0;
            tick();
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (i < 5) bus8.sel = seq[i];
                bus1.sel = ~bus1.sel;
                tick();
                if (i < 5) check($sformatf("seq_cnt%0d", i), {24'd0, bus8.toggle_cnt}, exp8[i]);
                check($sformatf("sat_cnt%0d", i), {30'd0, bus1.toggle_cnt}, exp1[i]);
            end
        end

        // Glitch between edges is not counted.
        bus8.sel = 1'b0;
        tick();
        bus8.sel = 1'b1;
        #2 bus8.sel = 1'b0;
        tick();
        check("glitch_cnt", {24'd0, bus8.toggle_cnt}, 32'd4);

        // Mid-run reset with toggle_cnt=5 and a nonzero y_q.
        rst = 1'b1; bus8.sel = 1'b0;
        tick();
        rst = 1'b0; bus8.a = 8'h11; bus8.b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            bus8.sel = ~bus8.sel;
            tick();
        end
        check("mid_cnt5", {24'd0, bus8.toggle_cnt}, 32'd5);
        check("mid_yq_nz", {31'd0, bus8.y_q != 8'h00}, 32'd1);
        rst = 1'b1; bus8.sel = ~bus8.sel; bus8.a = 8'h33;
        #1 check("mid_rst_y", {24'd0, bus8.y}, 32'h33);
        tick();
        check("mid_rst_cnt", {24'd0, bus8.toggle_cnt}, 32'd0);
        check("mid_rst_yq", {24'd0, bus8.y_q}, 32'd0);
        check("mid_rst_selq", {31'd0, bus8.sel_q}, 32'd0);
        rst = 1'b0; bus8.sel = 1'b1;
        tick();
        check("post_rst_cnt", {24'd0, bus8.toggle_cnt}, 32'd1);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 24) == 0);
            bus8.a   = 8'($urandom);
            bus8.b   = 8'($urandom);
            bus8.sel = 1'($urandom);
            bus1.a   = 1'($urandom);
            bus1.b   = 1'($urandom);
            bus1.sel = 1'($urandom);
            #1;
            check("rnd_y8", {24'd0, bus8.y}, {24'd0, (bus8.sel ? bus8.b : bus8.a)});
            check("rnd_y1", {31'd0, bus1.y}, {31'd0, (bus1.sel ? bus1.b : bus1.a)});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
